pwm_gen: RTL and testbench
==========================

// Module: pwm_gen
// PURPOSE
//   PWM generator core, downstream of the PWM bus peripheral. Consumes period/duty words
//   written by the CPU and produces the pwmout pin plus a per-period status flag that the
//   peripheral reads back. Period/duty are double-buffered so updates take effect only on
//   a period boundary: no runt or glitch pulses.
// PARAMETERS
//   WIDTH      32   counter, period and duty width in bits
//   RST_PER    0    active period after reset (0 = generator parked)
//   RST_DUTY   0    active duty after reset
// PORTS
//   clk         in   1      system clock; all logic on rising edge
//   rst         in   1      synchronous reset, active-high
//   en          in   1      run enable (level)
//   load        in   1      1-cycle strobe: capture period/duty into pending regs
//   period      in   WIDTH  period in clk cycles
//   duty        in   WIDTH  high time in clk cycles
//   clr_done    in   1      1-cycle strobe: clear done_flag
//   pwmout      out  1      PWM output, registered
//   cycle_done  out  1      1-cycle pulse on the last cycle of each period
//   done_flag   out  1      sticky copy of cycle_done, read back by the peripheral
//   busy        out  1      1 while state == RUN
// BEHAVIOUR
// - Reset (sync, high): state=IDLE, cnt=0, per_act=RST_PER, duty_act=RST_DUTY,
//   pend_valid=0, pwmout=0, cycle_done=0, done_flag=0, busy=0.
// - Pending regs: load=1 -> pend_per<=period, pend_duty<=duty, pend_valid<=1. A later
//   load before transfer overwrites the earlier one (last write wins).
// - Transfer pend->act (pend_valid<=0): (a) in IDLE, on the edge after pend_valid=1;
//   (b) in RUN, at the edge ending a cycle with cnt==per_act-1. Transfer uses pending
//   values as held before that edge; a load in the same cycle becomes the new pending
//   (pend_valid stays 1).
// - FSM IDLE: cnt=0, pwmout=0. Go RUN when en=1 && per_act!=0 (per_act after any
//   same-edge transfer); first RUN cycle has cnt=0.
// - FSM RUN: cnt counts 0..per_act-1, then wraps to 0 (at wrap, compare uses newly
//   transferred values). en=0 -> IDLE on the next edge; cnt<=0, pwmout<=0 immediately,
//   no period completion, no cycle_done. Transfer at boundary giving per_act==0 ->
//   IDLE, pwmout 0.
// - pwmout is a flop: it equals (state==RUN && cnt<duty_act) for the cnt value of the
//   same cycle, computed from next-state values. No combinational path to the pin.
// - Duty rules (unsigned compare): duty_act==0 -> constantly 0; duty_act>=per_act ->
//   constantly 1 while running; per_act==1 -> pwmout=1 iff duty_act>=1.
// - cycle_done=1 exactly in RUN cycles with cnt==per_act-1 (every cycle if per_act==1).
// - done_flag: set by cycle_done, cleared by clr_done; set wins when both are active
//   in the same cycle.
// - busy = (state==RUN). Width: cnt is WIDTH bits; per_act-1 never underflows because
//   RUN requires per_act!=0. A mid-operation rst returns every register to its reset
//   value on that edge.
// TESTING
// 1. rst; load per=10,duty=3; en=1 -> pwmout high 3 clk / low 7 clk, repeating;
//    cycle_done pulses every 10 clk at cnt=9; done_flag=1 after first period.
// 2. Running 10/3; load per=4,duty=2 at cnt=5 -> remainder of 10/3 period unchanged,
//    next period 2 high / 2 low, no glitch at the boundary.
// 3. duty=0 -> pwmout stuck 0; duty=10, per=10 -> stuck 1; duty=15, per=10 -> stuck 1;
//    per=1, duty=1 -> pwmout 1 and cycle_done 1 every cycle.
// 4. Load per=0 while running -> current period completes, then IDLE, busy=0,
//    pwmout=0; load per=6 with en still 1 -> RUN restarts with cnt=0.
// 5. Drop en at cnt=2 of a 10/5 period -> next edge pwmout=0, busy=0, no cycle_done;
//    raise clr_done coincident with cycle_done -> done_flag remains 1.
// 6. Assert rst at cnt=7 -> all outputs 0 on that edge; pend_valid cleared, so
//    per_act=RST_PER and duty_act=RST_DUTY.

Source files
------------

// File: rtl/pwm_gen.sv
// pwm_gen: PWM generator core with double-buffered period/duty.
//   Period/duty written via load land in pending registers and move to the active
//   registers only on a period boundary (or straight away while idle), so the pin
//   never shows a runt or glitch pulse.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   en            run enable (level)
//   load          strobe: capture period/duty into the pending registers
//   period, duty  requested period and high time, in clk cycles
//   clr_done      strobe: clear done_flag
//   pwmout        registered PWM pin
//   cycle_done    pulse on the last cycle of every period
//   done_flag     sticky copy of cycle_done
//   busy          high while the generator is running
module pwm_gen #(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] RST_PER  = '0,
  parameter logic [WIDTH-1:0] RST_DUTY = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] duty,
  input  logic             clr_done,
  output logic             pwmout,
  output logic             cycle_done,
  output logic             done_flag,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_act_q, per_act_d;
  logic [WIDTH-1:0] duty_act_q, duty_act_d;
  logic [WIDTH-1:0] pend_per_q, pend_per_d;
  logic [WIDTH-1:0] pend_duty_q, pend_duty_d;
  logic             pend_valid_q, pend_valid_d;
  logic             pwmout_q, pwmout_d;
  logic             cycle_done_q, cycle_done_d;
  logic             done_flag_q, done_flag_d;
  logic             busy_q, busy_d;
  logic             xfer;
  logic             per_last;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      per_act_q    <= RST_PER;
      duty_act_q   <= RST_DUTY;
      pend_per_q   <= '0;
      pend_duty_q  <= '0;
      pend_valid_q <= 1'b0;
      pwmout_q     <= 1'b0;
      cycle_done_q <= 1'b0;
      done_flag_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      per_act_q    <= per_act_d;
      duty_act_q   <= duty_act_d;
      pend_per_q   <= pend_per_d;
      pend_duty_q  <= pend_duty_d;
      pend_valid_q <= pend_valid_d;
      pwmout_q     <= pwmout_d;
      cycle_done_q <= cycle_done_d;
      done_flag_q  <= done_flag_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state, buffer transfer and registered-output computation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    per_act_d    = per_act_q;
    duty_act_d   = duty_act_q;
    pend_per_d   = pend_per_q;
    pend_duty_d  = pend_duty_q;
    pend_valid_d = pend_valid_q;
    xfer         = 1'b0;
    // RUN is only entered with per_act_q != 0, so the subtraction cannot wrap there
    per_last     = (cnt_q == (per_act_q - WIDTH'(1)));

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pend_valid_q) begin
          xfer       = 1'b1;
          per_act_d  = pend_per_q;
          duty_act_d = pend_duty_q;
        end
        if (en && (per_act_d != '0)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!en) begin
          // Abandon the period: no completion, no transfer
          state_d = IDLE;
          cnt_d   = '0;
        end else if (per_last) begin
          cnt_d = '0;
          if (pend_valid_q) begin
            xfer       = 1'b1;
            per_act_d  = pend_per_q;
            duty_act_d = pend_duty_q;
          end
          if (per_act_d == '0) begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A load on the transfer edge becomes the new pending value
    if (xfer) begin
      pend_valid_d = 1'b0;
    end
    if (load) begin
      pend_per_d   = period;
      pend_duty_d  = duty;
      pend_valid_d = 1'b1;
    end

    // Outputs describe the cycle that starts at the coming edge
    busy_d       = (state_d == RUN);
    pwmout_d     = (state_d == RUN) && (cnt_d < duty_act_d);
    cycle_done_d = (state_d == RUN) && (cnt_d == (per_act_d - WIDTH'(1)));
    // Set from the visible cycle_done takes priority over clear
    done_flag_d  = cycle_done_q || (done_flag_q && !clr_done);
  end

  assign pwmout     = pwmout_q;
  assign cycle_done = cycle_done_q;
  assign done_flag  = done_flag_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: directed bench for pwm_gen. Outputs are sampled 1 time unit after the
// rising edge; obs packs {pwmout, cycle_done, done_flag, busy}.
module tb_pwm_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic        load;
  logic [31:0] period;
  logic [31:0] duty;
  logic        clr_done;
  logic        pwmout;
  logic        cycle_done;
  logic        done_flag;
  logic        busy;
  logic [3:0]  obs;

  int vectors;
  int miscompares;

  pwm_gen #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .period    (period),
    .duty      (duty),
    .clr_done  (clr_done),
    .pwmout    (pwmout),
    .cycle_done(cycle_done),
    .done_flag (done_flag),
    .busy      (busy)
  );

  assign obs = {pwmout, cycle_done, done_flag, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; clr_done = 1'b0; period = '0; duty = '0;
    tick(); tick();
    vectors++;
    if (obs !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_hold obs=%b want=%b", obs, 4'b0000);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (obs !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_release obs=%b want=%b", obs, 4'b0000);
    end
  endtask

  // 10/3 from idle: 3 high, 7 low, cycle_done at cnt 9, done_flag after first period
  task automatic test_basic();
    logic [3:0] exp;
    int c;
    load = 1'b1; period = 32'd10; duty = 32'd3; en = 1'b1;
    tick();
    load = 1'b0;
    vectors++;
    if (obs !== 4'b0000) begin
      miscompares++;
      $display("FAIL basic_pending obs=%b want=%b", obs, 4'b0000);
    end
    tick();
    for (int i = 0; i < 25; i++) begin
      c = i % 10;
      exp = {c < 3, c == 9, i >= 10, 1'b1};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL basic i=%0d obs=%b want=%b", i, obs, exp);
      end
      tick();
    end
  endtask

  // Reload to 4/2 at cnt 5: current 10/3 period finishes untouched
  task automatic test_reload();
    logic [3:0] exp;
    int c, p, d;
    load = 1'b1; period = 32'd4; duty = 32'd2;
    tick();
    load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i < 4) begin
        c = 6 + i; p = 10; d = 3;
      end else begin
        c = (i - 4) % 4; p = 4; d = 2;
      end
      exp = {c < d, c == p - 1, 1'b1, 1'b1};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL reload i=%0d obs=%b want=%b", i, obs, exp);
      end
      tick();
    end
  endtask

  // Duty corner cases: 0 -> stuck low, >= period -> stuck high, period 1
  task automatic test_duty();
    int per_t [4] = '{10, 10, 10, 1};
    int duty_t[4] = '{0, 10, 15, 1};
    logic pwm_t[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] exp;
    int c;
    for (int j = 0; j < 4; j++) begin
      en = 1'b0;
      tick();
      vectors++;
      if (obs !== 4'b0010) begin
        miscompares++;
        $display("FAIL duty_stop j=%0d obs=%b want=%b", j, obs, 4'b0010);
      end
      load = 1'b1; period = 32'(per_t[j]); duty = 32'(duty_t[j]);
      tick();
      load = 1'b0; en = 1'b1;
      tick();
      for (int i = 0; i < 2 * per_t[j]; i++) begin
        c = i % per_t[j];
        exp = {pwm_t[j], c == per_t[j] - 1, 1'b1, 1'b1};
        vectors++;
        if (obs !== exp) begin
          miscompares++;
          $display("FAIL duty j=%0d i=%0d obs=%b want=%b", j, i, obs, exp);
        end
        tick();
      end
    end
  endtask

  // Period 0 loaded while running parks the generator after the current period
  task automatic test_zero_period();
    logic [3:0] exp;
    en = 1'b0;
    tick();
    load = 1'b1; period = 32'd5; duty = 32'd2;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    vectors++;
    if (obs !== 4'b1011) begin
      miscompares++;
      $display("FAIL zp_start obs=%b want=%b", obs, 4'b1011);
    end
    load = 1'b1; period = 32'd0; duty = 32'd0;
    tick();
    load = 1'b0;
    for (int c = 1; c < 5; c++) begin
      exp = {c < 2, c == 4, 1'b1, 1'b1};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL zp_finish cnt=%0d obs=%b want=%b", c, obs, exp);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs !== 4'b0010) begin
        miscompares++;
        $display("FAIL zp_parked i=%0d obs=%b want=%b", i, obs, 4'b0010);
      end
      tick();
    end
    load = 1'b1; period = 32'd6; duty = 32'd4;
    tick();
    load = 1'b0;
    vectors++;
    if (obs !== 4'b0010) begin
      miscompares++;
      $display("FAIL zp_pending obs=%b want=%b", obs, 4'b0010);
    end
    tick();
    for (int c = 0; c < 6; c++) begin
      exp = {c < 4, c == 5, 1'b1, 1'b1};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL zp_restart cnt=%0d obs=%b want=%b", c, obs, exp);
      end
      tick();
    end
  endtask

  // en drop mid-period, then clr_done racing cycle_done
  task automatic test_en_drop();
    logic [3:0] exp;
    int c;
    en = 1'b0; clr_done = 1'b1;
    tick();
    clr_done = 1'b0;
    vectors++;
    if (obs !== 4'b0000) begin
      miscompares++;
      $display("FAIL en_clear obs=%b want=%b", obs, 4'b0000);
    end
    load = 1'b1; period = 32'd10; duty = 32'd5;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs !== 4'b1001) begin
        miscompares++;
        $display("FAIL en_run cnt=%0d obs=%b want=%b", i, obs, 4'b1001);
      end
      if (i < 2) tick();
    end
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (obs !== 4'b0000) begin
        miscompares++;
        $display("FAIL en_drop i=%0d obs=%b want=%b", i, obs, 4'b0000);
      end
    end
    en = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      c = i % 10;
      exp = {c < 5, c == 9, i >= 10, 1'b1};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL en_resume i=%0d obs=%b want=%b", i, obs, exp);
      end
      if (i == 19) clr_done = 1'b1;
      tick();
    end
    clr_done = 1'b0;
    vectors++;
    if (obs !== 4'b1011) begin
      miscompares++;
      $display("FAIL set_wins obs=%b want=%b", obs, 4'b1011);
    end
    clr_done = 1'b1;
    tick();
    clr_done = 1'b0;
    vectors++;
    if (obs !== 4'b1001) begin
      miscompares++;
      $display("FAIL clr_done obs=%b want=%b", obs, 4'b1001);
    end
  endtask

  // Reset at cnt 7 with a pending load outstanding
  task automatic test_mid_reset();
    logic [3:0] exp;
    for (int c = 1; c < 7; c++) begin
      load = (c == 3);
      period = 32'd8; duty = 32'd8;
      exp = {c < 5, 1'b0, 1'b0, 1'b1};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL mr_run cnt=%0d obs=%b want=%b", c, obs, exp);
      end
      tick();
    end
    load = 1'b0;
    vectors++;
    if (obs !== 4'b0001) begin
      miscompares++;
      $display("FAIL mr_cnt7 obs=%b want=%b", obs, 4'b0001);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (obs !== 4'b0000) begin
      miscompares++;
      $display("FAIL mr_edge obs=%b want=%b", obs, 4'b0000);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (obs !== 4'b0000) begin
        miscompares++;
        $display("FAIL mr_parked i=%0d obs=%b want=%b", i, obs, 4'b0000);
      end
    end
  endtask

  // Two loads in consecutive cycles mid-period: the later one is applied
  task automatic test_back_to_back();
    logic [3:0] exp;
    int c, p, d;
    en = 1'b0;
    load = 1'b1; period = 32'd7; duty = 32'd1;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    vectors++;
    if (obs !== 4'b1001) begin
      miscompares++;
      $display("FAIL b2b_start obs=%b want=%b", obs, 4'b1001);
    end
    load = 1'b1; period = 32'd5; duty = 32'd5;
    tick();
    vectors++;
    if (obs !== 4'b0001) begin
      miscompares++;
      $display("FAIL b2b_cnt1 obs=%b want=%b", obs, 4'b0001);
    end
    period = 32'd3; duty = 32'd2;
    tick();
    load = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i < 5) begin
        c = 2 + i; p = 7; d = 1;
      end else begin
        c = (i - 5) % 3; p = 3; d = 2;
      end
      exp = {c < d, c == p - 1, i >= 5, 1'b1};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL b2b i=%0d obs=%b want=%b", i, obs, exp);
      end
      tick();
    end
    en = 1'b0;
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_reload();
    test_duty();
    test_zero_period();
    test_en_drop();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
